// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 operand-entry controller: state encodings and debounce defaults.
package alu4_pkg;

  localparam int unsigned DATA_W              = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned CNT_W_DEF           = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GOT_A = 2'd1,
    ST_EXEC  = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key: 2-flop synchroniser, stable-level debounce, one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  // Count consecutive samples differing from the accepted level; any agreeing sample restarts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ripple_subtractor4.sv
// 4-bit ripple subtractor datapath: magnitude of a-b and carry out (1 = non-negative).
module ripple_subtractor4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;
  logic [3:0] diff;

  // a + ~b + 1 through a chain of full adders, then negate when the result is negative.
  always_comb begin
    c[0] = 1'b1;
    diff = '0;
    for (int i = 0; i < 4; i++) begin
      diff[i]  = a[i] ^ ~b[i] ^ c[i];
      c[i + 1] = (a[i] & ~b[i]) | (a[i] & c[i]) | (~b[i] & c[i]);
    end
    cout = c[4];
    s    = c[4] ? diff : 4'(~diff + 4'd1);
  end

endmodule

// File: rtl/alu4_operand_sequencer.sv
// Operand entry controller: captures A then B on debounced enter presses and holds the subtractor result.
module alu4_operand_sequencer
  import alu4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  sw_data,
  input  logic        key_enter_n,
  input  logic        key_clear_n,
  input  logic [3:0]  alu_s,
  input  logic        alu_cout,
  output logic [3:0]  op_a,
  output logic [3:0]  op_b,
  output logic [3:0]  result_mag,
  output logic        result_neg,
  output logic        result_valid,
  output logic [1:0]  state_out
);

  logic enter_p;
  logic clear_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (key_enter_n),
    .press  (enter_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (key_clear_n),
    .press  (clear_p)
  );

  state_t            state_q, state_d;
  logic [DATA_W-1:0] op_a_d, op_b_d, mag_d;
  logic              neg_d, valid_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      op_a         <= '0;
      op_b         <= '0;
      result_mag   <= '0;
      result_neg   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a         <= op_a_d;
      op_b         <= op_b_d;
      result_mag   <= mag_d;
      result_neg   <= neg_d;
      result_valid <= valid_d;
    end
  end

  // Clear takes priority over enter in every state, including an in-flight EXEC.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a;
    op_b_d  = op_b;
    mag_d   = result_mag;
    neg_d   = result_neg;
    valid_d = result_valid;
    if (clear_p) begin
      state_d = ST_IDLE;
      op_a_d  = '0;
      op_b_d  = '0;
      mag_d   = '0;
      neg_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enter_p) begin
            op_a_d  = sw_data;
            state_d = ST_GOT_A;
          end
        end
        ST_GOT_A: begin
          if (enter_p) begin
            op_b_d  = sw_data;
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          mag_d   = alu_s;
          neg_d   = ~alu_cout;
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (enter_p) begin
            op_a_d  = sw_data;
            valid_d = 1'b0;
            state_d = ST_GOT_A;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_alu4_operand_sequencer.sv
// Self-checking bench: key presses with bounce, directed and random operand pairs against a transaction model.
module tb_alu4_operand_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] sw_data;
  logic       key_enter_n, key_clear_n;
  logic [3:0] alu_s;
  logic       alu_cout;
  logic [3:0] op_a, op_b, result_mag;
  logic       result_neg, result_valid;
  logic [1:0] state_out;

  always #5 clk = ~clk;

  alu4_operand_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sw_data      (sw_data),
    .key_enter_n  (key_enter_n),
    .key_clear_n  (key_clear_n),
    .alu_s        (alu_s),
    .alu_cout     (alu_cout),
    .op_a         (op_a),
    .op_b         (op_b),
    .result_mag   (result_mag),
    .result_neg   (result_neg),
    .result_valid (result_valid),
    .state_out    (state_out)
  );

  ripple_subtractor4 u_sub (
    .a    (op_a),
    .b    (op_b),
    .s    (alu_s),
    .cout (alu_cout)
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: 0 idle, 1 waiting for B, 3 result shown.
  int m_state, m_a, m_b, m_mag, m_neg, m_valid;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_state = 0; m_a = 0; m_b = 0; m_mag = 0; m_neg = 0; m_valid = 0;
  endtask

  task automatic model_enter(input int sw);
    case (m_state)
      0: begin m_a = sw; m_state = 1; end
      1: begin
        m_b     = sw;
        m_neg   = (m_a < m_b) ? 1 : 0;
        m_mag   = (m_a < m_b) ? (m_b - m_a) : (m_a - m_b);
        m_valid = 1;
        m_state = 3;
      end
      default: begin m_a = sw; m_valid = 0; m_state = 1; end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, int'(state_out), m_state);
    check({tag, ".op_a"},  int'(op_a), m_a);
    check({tag, ".op_b"},  int'(op_b), m_b);
    check({tag, ".mag"},   int'(result_mag), m_mag);
    check({tag, ".neg"},   int'(result_neg), m_neg);
    check({tag, ".valid"}, int'(result_valid), m_valid);
  endtask

  // Clean press: hold low, then release. Optionally verify EXEC lasts exactly one cycle.
  task automatic press(input logic [3:0] sw, input bit both, input bit chk_exec);
    bit seen, done;
    seen = 0; done = 0;
    sw_data = sw;
    key_enter_n = 1'b0;
    if (both) key_clear_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (chk_exec && !done) begin
        if (seen) begin
          check("lat.state", int'(state_out), 3);
          check("lat.valid", int'(result_valid), 1);
          check("lat.mag", int'(result_mag), m_mag);
          check("lat.neg", int'(result_neg), m_neg);
          done = 1;
        end else if (state_out == 2'd2) begin
          check("lat.pre_valid", int'(result_valid), 0);
          seen = 1;
        end
      end
    end
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (10) @(negedge clk);
    if (chk_exec && !done) check("lat.exec_seen", 0, 1);
  endtask

  task automatic enter_pair(input int a, input int b, input string tag);
    model_enter(a);
    press(4'(a), 0, 0);
    model_enter(b);
    press(4'(b), 0, 1);
    check_all(tag);
  endtask

  initial begin
    bit hit;
    resetn = 1'b0; sw_data = '0; key_enter_n = 1'b1; key_clear_n = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check_all("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Short glitches never reach the debounce threshold.
    sw_data = 4'd9;
    for (int r = 0; r < 4; r++) begin
      key_enter_n = 1'b0; repeat (3) @(negedge clk);
      key_enter_n = 1'b1; repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("bounce.state", int'(state_out), 0);
    key_enter_n = 1'b0; repeat (20) @(negedge clk);
    key_enter_n = 1'b1; repeat (10) @(negedge clk);
    model_enter(9);
    check_all("stable_press");

    model_enter(3);
    press(4'd3, 0, 1);
    check_all("a9b3");

    model_enter(12);
    press(4'd12, 0, 0);
    check_all("show_reenter");

    model_enter(9);
    press(4'd9, 0, 1);
    check_all("a12b9");

    enter_pair(3, 9, "a3b9");
    enter_pair(0, 15, "a0b15");
    enter_pair(7, 7, "a7b7");

    model_enter(5);
    press(4'd5, 0, 0);
    check_all("got_a5");
    model_clear();
    press(4'd6, 1, 0);
    check_all("clear_enter");

    for (int it = 0; it < 10; it++) begin
      int a, b;
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        key_clear_n = 1'b0; repeat (12) @(negedge clk);
        key_clear_n = 1'b1; repeat (10) @(negedge clk);
        model_clear();
        check_all("rand_clear");
      end
      enter_pair(a, b, $sformatf("rand%0d_a%0d_b%0d", it, a, b));
    end

    // Reset asserted while EXEC is in flight.
    model_enter(4);
    press(4'd4, 0, 0);
    sw_data = 4'd11;
    key_enter_n = 1'b0;
    hit = 0;
    for (int i = 0; i < 15 && !hit; i++) begin
      @(negedge clk);
      if (state_out == 2'd2) hit = 1;
    end
    check("rst_exec.reached", int'(hit), 1);
    resetn = 1'b0;
    #1;
    model_clear();
    check_all("rst_exec.async");
    key_enter_n = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check_all("rst_exec.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
